// File: rtl/maxpool_relu_stream_pkg.sv
// Shared constants and types for the streaming 2x2 max-pool stage.
// Holds the fp16 constants the conv layer also relies on.
package maxpool_relu_stream_pkg;

    localparam int          DATA_WIDTH_DEF = 16;
    localparam logic [15:0] FP16_ZERO      = 16'h0000;
    localparam int          FP16_SIGN_BIT  = 15;

    // Position of the current pixel inside its 2x2 window, {row[0], col[0]}.
    typedef enum logic [1:0] {
        PH_TOP_LEFT  = 2'b00,
        PH_TOP_RIGHT = 2'b01,
        PH_BOT_LEFT  = 2'b10,
        PH_BOT_RIGHT = 2'b11
    } win_pos_e;

endpackage

// File: rtl/maxpool_relu_stream_if.sv
// Valid/ready stream bundle: a beat transfers on the rising edge where valid && ready;
// the master holds valid, data and last stable until that edge.
interface maxpool_relu_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/maxpool_relu_stream_fp16_max.sv
// Combinational fp16 maximum; +0 and -0 are equal and ties return operand a.
module fp16_max #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] y_o
);
    logic                  sign_a;
    logic                  sign_b;
    logic [DATA_WIDTH-2:0] mag_a;
    logic [DATA_WIDTH-2:0] mag_b;
    logic                  b_wins;

    assign sign_a = a_i[DATA_WIDTH-1];
    assign sign_b = b_i[DATA_WIDTH-1];
    assign mag_a  = a_i[DATA_WIDTH-2:0];
    assign mag_b  = b_i[DATA_WIDTH-2:0];

    // Non-NaN fp16 magnitudes order the same way as their unsigned bit patterns.
    always_comb begin
        b_wins = 1'b0;
        if (mag_a == '0 && mag_b == '0) begin
            b_wins = 1'b0;
        end else if (sign_a != sign_b) begin
            b_wins = sign_a;
        end else if (!sign_a) begin
            b_wins = (mag_b > mag_a);
        end else begin
            b_wins = (mag_b < mag_a);
        end
    end

    assign y_o = b_wins ? b_i : a_i;

endmodule

// File: rtl/maxpool_relu_stream.sv
// Streaming 2x2/stride-2 fp16 max-pool with raster in/out and a frame-last flag.
// Define RELU_EN to clamp negative inputs (including -0) to +0 before pooling.
module maxpool_relu_stream
    import maxpool_relu_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int H          = 28,
    parameter int W          = 28
) (
    input  logic                    clk,
    input  logic                    reset,
    maxpool_relu_stream_if.slave    in_i,
    maxpool_relu_stream_if.master   out_o
);
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);
    localparam int LD = W / 2;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;

    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [DATA_WIDTH-1:0] pair_q, pair_d;
    logic [DATA_WIDTH-1:0] lb_q [0:LD-1];
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;

    logic                  in_ready;
    logic                  xfer;
    logic                  row_last;
    logic                  col_last;
    logic [DATA_WIDTH-1:0] px;
    logic [DATA_WIDTH-1:0] h_max;
    logic [DATA_WIDTH-1:0] v_max;
    logic [LW-1:0]         lb_idx;
    win_pos_e              pos;
    logic                  unused_in_last;

    assign in_ready = !out_valid_q || out_o.ready;
    assign xfer     = in_i.valid && in_ready;
    assign row_last = (row_q == RW'(H - 1));
    assign col_last = (col_q == CW'(W - 1));
    assign lb_idx   = LW'(col_q >> 1);
    assign pos      = win_pos_e'({row_q[0], col_q[0]});

`ifdef RELU_EN
    assign px = in_i.data[FP16_SIGN_BIT] ? FP16_ZERO : in_i.data;
`else
    assign px = in_i.data;
`endif

    // Horizontal pair first, then merge with the row above held in the line buffer.
    fp16_max #(.DATA_WIDTH(DATA_WIDTH)) u_max_h (
        .a_i (pair_q),
        .b_i (px),
        .y_o (h_max)
    );

    fp16_max #(.DATA_WIDTH(DATA_WIDTH)) u_max_v (
        .a_i (lb_q[lb_idx]),
        .b_i (h_max),
        .y_o (v_max)
    );

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        pair_d = pair_q;
        if (xfer) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (!col_q[0]) begin
                pair_d = px;
            end
        end
    end

    // A window result may load in the same cycle the previous one pops.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (xfer && pos == PH_BOT_RIGHT) begin
            out_valid_d = 1'b1;
            out_data_d  = v_max;
            out_last_d  = row_last && col_last;
        end else if (out_valid_q && out_o.ready) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q       <= '0;
            col_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Every entry is written on an even row before the odd row reads it, so no reset.
    always_ff @(posedge clk) begin
        if (xfer && pos == PH_TOP_RIGHT) begin
            lb_q[lb_idx] <= h_max;
        end
    end

    assign in_i.ready  = in_ready;
    assign out_o.valid = out_valid_q;
    assign out_o.data  = out_data_q;
    assign out_o.last  = out_last_q;

    assign unused_in_last = in_i.last;

endmodule

// File: tb/tb_maxpool_relu_stream.sv
// Directed bench for maxpool_relu_stream: a 4x4 instance for hand-computed cases and
// a default 28x28 instance for two back-to-back frames under random gaps.
module tb_maxpool_relu_stream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    maxpool_relu_stream_if #(.DATA_WIDTH(16)) in4 ();
    maxpool_relu_stream_if #(.DATA_WIDTH(16)) out4 ();
    maxpool_relu_stream_if #(.DATA_WIDTH(16)) in28 ();
    maxpool_relu_stream_if #(.DATA_WIDTH(16)) out28 ();

    maxpool_relu_stream #(.DATA_WIDTH(16), .H(4), .W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .in_i  (in4),
        .out_o (out4)
    );

    maxpool_relu_stream #(.DATA_WIDTH(16)) dut28 (
        .clk   (clk),
        .reset (reset),
        .in_i  (in28),
        .out_o (out28)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] exp_q[$];
    logic [16:0] got4_q[$];
    logic [16:0] exp28_q[$];
    logic [16:0] got28_q[$];
    logic [15:0] img [0:1][0:783];
    logic        drv_done;

    // fp16 of 1..16 in raster order
    logic [15:0] seq [0:15] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                                16'h4500, 16'h4600, 16'h4700, 16'h4800,
                                16'h4880, 16'h4900, 16'h4980, 16'h4A00,
                                16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};

    // Scoreboard capture: a beat is recorded when valid && ready ahead of the next edge.
    always @(negedge clk) begin
        if (out4.valid && out4.ready) got4_q.push_back({out4.last, out4.data});
        if (out28.valid && out28.ready) got28_q.push_back({out28.last, out28.data});
    end

    function automatic logic [15:0] ref_max(input logic [15:0] a, input logic [15:0] b);
        int ka;
        int kb;
        ka = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
        kb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
        return (kb > ka) ? b : a;
    endfunction

    function automatic logic [15:0] relu_model(input logic [15:0] x);
`ifdef RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    task automatic send4(input logic [15:0] px);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        in4.valid = 1'b1;
        in4.data  = px;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = in4.ready;
            @(posedge clk);
            #1;
            n++;
        end
        in4.valid = 1'b0;
        in4.data  = 16'($urandom);
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send4_accept got=timeout exp=accepted px=%h", px);
        end
    endtask

    task automatic send28(input logic [15:0] px, input int gap);
        logic acc;
        int   n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        acc = 1'b0;
        n   = 0;
        in28.valid = 1'b1;
        in28.data  = px;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = in28.ready;
            @(posedge clk);
            #1;
            n++;
        end
        in28.valid = 1'b0;
        in28.data  = 16'($urandom);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send28_accept got=timeout exp=accepted px=%h", px);
        end
    endtask

    task automatic wait_out4(input int n);
        int k;
        k = 0;
        while (got4_q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 5;
        if (out4.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out4.valid); end
        if (out4.data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out4.data); end
        if (out4.last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", out4.last); end
        if (in4.ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in4.ready); end
        if (out28.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid28 got=%b exp=0", out28.valid); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        got4_q.delete();
        exp_q.delete();
        exp_q.push_back({1'b0, 16'h4600});
        exp_q.push_back({1'b0, 16'h4800});
        exp_q.push_back({1'b0, 16'h4B00});
        exp_q.push_back({1'b1, 16'h4C00});
        out4.ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send4(seq[i]);
            if (i == 5) begin
                n_checks++;
                if (out4.valid !== 1'b1 || out4.data !== 16'h4600) begin
                    n_fail++;
                    $display("FAIL basic_latency got=%b/%h exp=1/4600", out4.valid, out4.data);
                end
            end
        end
        wait_out4(4);
        n_checks++;
        if (got4_q.size() != 4) begin n_fail++; $display("FAIL basic_count got=%0d exp=4", got4_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got4_q.size()) begin
                n_fail++; $display("FAIL basic_out%0d got=missing exp=%h", i, exp_q[i]);
            end else if (got4_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_out%0d got=%h exp=%h", i, got4_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        got4_q.delete();
        exp_q.delete();
        exp_q.push_back({1'b0, 16'h4600});
        exp_q.push_back({1'b0, 16'h4800});
        exp_q.push_back({1'b0, 16'h4B00});
        exp_q.push_back({1'b1, 16'h4C00});
        out4.ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send4(seq[i]);
            end
            begin
                k = 0;
                while (out4.valid !== 1'b1 && k < 300) begin
                    @(negedge clk);
                    k++;
                end
                n_checks++;
                if (k >= 300) begin n_fail++; $display("FAIL hold_first_valid got=timeout exp=valid"); end
                for (int j = 0; j < 5; j++) begin
                    n_checks++;
                    if (in4.ready !== 1'b0 || out4.valid !== 1'b1 || out4.data !== 16'h4600) begin
                        n_fail++;
                        $display("FAIL hold_cycle%0d got=rdy%b/vld%b/%h exp=rdy0/vld1/4600",
                                 j, in4.ready, out4.valid, out4.data);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out4.ready = 1'b1;
            end
        join
        wait_out4(4);
        n_checks++;
        if (got4_q.size() != 4) begin n_fail++; $display("FAIL hold_count got=%0d exp=4", got4_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got4_q.size()) begin
                n_fail++; $display("FAIL hold_out%0d got=missing exp=%h", i, exp_q[i]);
            end else if (got4_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL hold_out%0d got=%h exp=%h", i, got4_q[i], exp_q[i]);
            end
        end
    endtask

    // Window 0: signed zeros, window 1: equal ones, window 2: all negative, window 3: 1..4.
    task automatic test_windows();
        logic [15:0] frame [0:15];
        frame = '{16'h0000, 16'h8000, 16'h3C00, 16'h3C00,
                  16'h8000, 16'h0000, 16'h3C00, 16'h3C00,
                  16'hBC00, 16'hC000, 16'h3C00, 16'h4000,
                  16'hB800, 16'hC200, 16'h4200, 16'h4400};
        got4_q.delete();
        exp_q.delete();
        exp_q.push_back({1'b0, 16'h0000});
        exp_q.push_back({1'b0, 16'h3C00});
`ifdef RELU_EN
        exp_q.push_back({1'b0, 16'h0000});
`else
        exp_q.push_back({1'b0, 16'hB800});
`endif
        exp_q.push_back({1'b1, 16'h4400});
        out4.ready = 1'b1;
        for (int i = 0; i < 16; i++) send4(frame[i]);
        wait_out4(4);
        n_checks++;
        if (got4_q.size() != 4) begin n_fail++; $display("FAIL win_count got=%0d exp=4", got4_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got4_q.size()) begin
                n_fail++; $display("FAIL win_out%0d got=missing exp=%h", i, exp_q[i]);
            end else if (got4_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL win_out%0d got=%h exp=%h", i, got4_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        got4_q.delete();
        out4.ready = 1'b1;
        for (int i = 0; i < 9; i++) send4(seq[i]);
        wait_out4(2);
        n_checks++;
        if (got4_q.size() != 2) begin n_fail++; $display("FAIL mid_pre_count got=%0d exp=2", got4_q.size()); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out4.valid !== 1'b0 || in4.ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_state got=vld%b/rdy%b exp=vld0/rdy1", out4.valid, in4.ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        got4_q.delete();
        exp_q.delete();
        exp_q.push_back({1'b0, 16'h4600});
        exp_q.push_back({1'b0, 16'h4800});
        exp_q.push_back({1'b0, 16'h4B00});
        exp_q.push_back({1'b1, 16'h4C00});
        for (int i = 0; i < 16; i++) send4(seq[i]);
        wait_out4(4);
        n_checks++;
        if (got4_q.size() != 4) begin n_fail++; $display("FAIL mid_count got=%0d exp=4", got4_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got4_q.size()) begin
                n_fail++; $display("FAIL mid_out%0d got=missing exp=%h", i, exp_q[i]);
            end else if (got4_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL mid_out%0d got=%h exp=%h", i, got4_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] px;
        logic [15:0] top;
        logic [15:0] bot;
        int          base;
        int          c;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 784; i++) begin
                px = 16'($urandom);
                if (px[14:10] == 5'h1F) px[14] = 1'b0;
                img[f][i] = px;
            end
        end
        exp28_q.delete();
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 14; r++) begin
                for (int cc = 0; cc < 14; cc++) begin
                    base = (2 * r) * 28 + 2 * cc;
                    top  = ref_max(relu_model(img[f][base]), relu_model(img[f][base + 1]));
                    bot  = ref_max(relu_model(img[f][base + 28]), relu_model(img[f][base + 29]));
                    exp28_q.push_back({(r == 13 && cc == 13), ref_max(top, bot)});
                end
            end
        end
        got28_q.delete();
        drv_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 2; f++) begin
                    for (int i = 0; i < 784; i++) send28(img[f][i], $urandom_range(0, 2));
                end
                drv_done = 1'b1;
            end
            begin
                c = 0;
                while ((!drv_done || got28_q.size() < 392) && c < 40000) begin
                    @(posedge clk);
                    #1;
                    out28.ready = ($urandom_range(0, 3) != 0);
                    c++;
                end
                out28.ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        n_checks++;
        if (got28_q.size() != 392) begin n_fail++; $display("FAIL frames_count got=%0d exp=392", got28_q.size()); end
        for (int i = 0; i < exp28_q.size(); i++) begin
            n_checks++;
            if (i >= got28_q.size()) begin
                n_fail++; $display("FAIL frames_out%0d got=missing exp=%h", i, exp28_q[i]);
            end else if (got28_q[i] !== exp28_q[i]) begin
                n_fail++; $display("FAIL frames_out%0d got=%h exp=%h", i, got28_q[i], exp28_q[i]);
            end
        end
    endtask

    initial begin
        reset       = 1'b0;
        in4.valid   = 1'b0;
        in4.data    = 16'h0000;
        in4.last    = 1'b0;
        out4.ready  = 1'b1;
        in28.valid  = 1'b0;
        in28.data   = 16'h0000;
        in28.last   = 1'b0;
        out28.ready = 1'b1;
        drv_done    = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_windows();
        test_reset_midframe();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
